seq_run_monitor: RTL and testbench

SEQ_RUN_MONITOR -- requirements
Module: seq_run_monitor

---
 rtl/seq_run_monitor_pkg.sv | 15 +
 rtl/seq_run_monitor_if.sv | 33 +++
 rtl/seq_run_monitor_sat_counter.sv | 31 +++
 rtl/seq_run_monitor.sv | 145 ++++++++++++++
 tb/tb_seq_run_monitor.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_run_monitor_pkg.sv
// Shared types and constants for the serial run-length monitor.
package seq_run_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ALARM = 2'd2
  } state_t;

  localparam int RUN_W = 4;
  localparam logic [RUN_W-1:0] RUN_SAT = 4'd15;
  // Shortest run the upstream 111/000 detector fires on.
  localparam logic [RUN_W-1:0] DET_MIN = 4'd3;

endpackage

// File: rtl/seq_run_monitor_if.sv
// Bundle of the monitor's data inputs and statistics outputs.
interface seq_run_monitor_if #(
  parameter int CNT_W = 8
);
  import seq_run_monitor_pkg::*;

  logic             x;
  logic             det;
  logic             clr;
  logic [CNT_W-1:0] ones_cnt;
  logic [CNT_W-1:0] zeros_cnt;
  logic [RUN_W-1:0] run_len;
  logic [RUN_W-1:0] max_run;
  logic             evt_valid;
  logic             evt_type;
  logic             alarm;
  logic             err;

  // Stimulus side: drives the bit stream, observes statistics.
  modport master (
    output x, det, clr,
    input  ones_cnt, zeros_cnt, run_len, max_run,
    input  evt_valid, evt_type, alarm, err
  );

  // Monitor side.
  modport slave (
    input  x, det, clr,
    output ones_cnt, zeros_cnt, run_len, max_run,
    output evt_valid, evt_type, alarm, err
  );

endinterface

// File: rtl/seq_run_monitor_sat_counter.sv
// Saturating event counter with synchronous reset and clear.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Count enabled events, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_p1 <= '0;
    end else if (en) begin
      cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign cnt = cnt_p1;

endmodule

// File: rtl/seq_run_monitor.sv
// Run-length monitor that shadows an upstream 111/000 Mealy detector,
// counts its detections and flags any disagreement with the local run count.
module seq_run_monitor
  import seq_run_monitor_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int ALARM_LEN = 6
) (
  input  logic               clk,
  input  logic               rst,
  seq_run_monitor_if.slave   bus
);

  localparam logic [RUN_W-1:0] ALARM_TH = RUN_W'(ALARM_LEN);

  state_t           state_p1;
  state_t           state_nxt;
  logic             prev_vld_p1;
  logic             prev_bit_p1;
  logic [RUN_W-1:0] run_len_p1;
  logic [RUN_W-1:0] max_run_p1;
  logic             evt_valid_p1;
  logic             evt_type_p1;
  logic             err_p1;
  logic [RUN_W-1:0] eff_len_p0;
  logic             toggle_p0;
  logic             accept_p0;
  logic             mismatch_p0;
  logic [CNT_W-1:0] ones_p1;
  logic [CNT_W-1:0] zeros_p1;

  // Run length including the current bit, saturating at RUN_SAT.
  function automatic logic [RUN_W-1:0] next_len(input logic             xb,
                                                 input logic             pb,
                                                 input logic             pv,
                                                 input logic [RUN_W-1:0] len);
    if (!pv || (xb != pb)) begin
      return RUN_W'(1);
    end else if (len == RUN_SAT) begin
      return RUN_SAT;
    end else begin
      return len + 1'b1;
    end
  endfunction

  function automatic logic [RUN_W-1:0] max_len(input logic [RUN_W-1:0] a,
                                                input logic [RUN_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // ---- stage p0: combinational view of the incoming bit ----
  // Derive effective run length, toggle, acceptance and consistency check.
  always_comb begin
    eff_len_p0  = next_len(bus.x, prev_bit_p1, prev_vld_p1, run_len_p1);
    toggle_p0   = prev_vld_p1 && (bus.x != prev_bit_p1);
    accept_p0   = bus.det && !bus.clr;
    mismatch_p0 = bus.det ? (eff_len_p0 < DET_MIN) : (eff_len_p0 >= DET_MIN);
  end

  // ---- stage p1: registered state ----
  // Run tracking survives clr so it stays aligned with the upstream detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vld_p1 <= 1'b0;
      prev_bit_p1 <= 1'b0;
      run_len_p1  <= '0;
    end else begin
      prev_vld_p1 <= 1'b1;
      prev_bit_p1 <= bus.x;
      run_len_p1  <= eff_len_p0;
    end
  end

  // Statistics: max run, event pulse, sticky error; clr wins over det.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      max_run_p1   <= '0;
      evt_valid_p1 <= 1'b0;
      err_p1       <= 1'b0;
    end else begin
      max_run_p1   <= max_len(max_run_p1, eff_len_p0);
      evt_valid_p1 <= accept_p0;
      err_p1       <= err_p1 | mismatch_p0;
    end
  end

  // Event type holds the bit of the most recent accepted detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_type_p1 <= 1'b0;
    end else if (accept_p0) begin
      evt_type_p1 <= bus.x;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= IDLE;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  // FSM next state: arm on first detection, alarm on long runs, drop on toggle.
  always_comb begin
    state_nxt = state_p1;
    if (bus.clr) begin
      state_nxt = IDLE;
    end else begin
      unique case (state_p1)
        IDLE:    if (accept_p0)              state_nxt = TRACK;
        TRACK:   if (eff_len_p0 >= ALARM_TH) state_nxt = ALARM;
        ALARM:   if (toggle_p0)              state_nxt = TRACK;
        default:                             state_nxt = IDLE;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_ones (
    .clk (clk),
    .rst (rst),
    .clr (bus.clr),
    .en  (accept_p0 && bus.x),
    .cnt (ones_p1)
  );

  sat_counter #(.CNT_W(CNT_W)) u_zeros (
    .clk (clk),
    .rst (rst),
    .clr (bus.clr),
    .en  (accept_p0 && !bus.x),
    .cnt (zeros_p1)
  );

  assign bus.ones_cnt  = ones_p1;
  assign bus.zeros_cnt = zeros_p1;
  assign bus.run_len   = run_len_p1;
  assign bus.max_run   = max_run_p1;
  assign bus.evt_valid = evt_valid_p1;
  assign bus.evt_type  = evt_type_p1;
  assign bus.alarm     = (state_p1 == ALARM);
  assign bus.err       = err_p1;

endmodule

// File: tb/tb_seq_run_monitor.sv
// Bench for seq_run_monitor: directed scenarios plus randomized bit streams
// compared every cycle against a behavioural model.
module tb_seq_run_monitor;

  localparam int AL = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_run_monitor_if #(.CNT_W(8)) bus ();
  seq_run_monitor_if #(.CNT_W(2)) bus2 ();

  assign bus2.x   = bus.x;
  assign bus2.det = bus.det;
  assign bus2.clr = bus.clr;

  seq_run_monitor #(.CNT_W(8), .ALARM_LEN(AL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seq_run_monitor #(.CNT_W(2), .ALARM_LEN(AL)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  // Model state: what the outputs must read after each clock edge.
  bit m_pv, m_prev, m_ev, m_et, m_err;
  int m_run, m_ones, m_zeros, m_ones2, m_zeros2, m_max, m_mode; // mode 0 idle,1 track,2 alarm

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_eff(input bit xi);
    if (!m_pv || xi != m_prev) return 1;
    return (m_run + 1 > 15) ? 15 : m_run + 1;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic m_update(input bit xi, input bit di, input bit ci, input bit ri);
    int e;
    bit tog;
    if (ri) begin
      m_pv = 0; m_prev = 0; m_run = 0; m_ones = 0; m_zeros = 0; m_ones2 = 0;
      m_zeros2 = 0; m_max = 0; m_ev = 0; m_et = 0; m_err = 0; m_mode = 0;
    end else begin
      e   = m_eff(xi);
      tog = m_pv && (xi != m_prev);
      m_run = e; m_prev = xi; m_pv = 1;
      if (ci) begin
        m_ones = 0; m_zeros = 0; m_ones2 = 0; m_zeros2 = 0;
        m_max = 0; m_ev = 0; m_err = 0; m_mode = 0;
      end else begin
        if (di) begin
          if (xi) begin m_ones = sat(m_ones + 1, 255); m_ones2 = sat(m_ones2 + 1, 3); end
          else    begin m_zeros = sat(m_zeros + 1, 255); m_zeros2 = sat(m_zeros2 + 1, 3); end
          m_ev = 1; m_et = xi;
        end else begin
          m_ev = 0;
        end
        if (e > m_max) m_max = e;
        if ((di && e < 3) || (!di && e >= 3)) m_err = 1;
        case (m_mode)
          0: if (di) m_mode = 1;
          1: if (e >= AL) m_mode = 2;
          2: if (tog) m_mode = 1;
          default: m_mode = 0;
        endcase
      end
    end
  endtask

  task automatic step(input bit xi, input bit di, input bit ci, input bit ri);
    bus.x = xi; bus.det = di; bus.clr = ci; rst = ri;
    @(posedge clk);
    m_update(xi, di, ci, ri);
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("ones_cnt",   bus.ones_cnt,  m_ones);
      cmp("zeros_cnt",  bus.zeros_cnt, m_zeros);
      cmp("run_len",    bus.run_len,   m_run);
      cmp("max_run",    bus.max_run,   m_max);
      cmp("evt_valid",  bus.evt_valid, m_ev);
      cmp("evt_type",   bus.evt_type,  m_et);
      cmp("alarm",      bus.alarm,     (m_mode == 2));
      cmp("err",        bus.err,       m_err);
      cmp("ones_cnt_w2",  bus2.ones_cnt,  m_ones2);
      cmp("zeros_cnt_w2", bus2.zeros_cnt, m_zeros2);
    end
  end

  initial begin
    bit xr, dr, cr, rr;
    bus.x = 0; bus.det = 0; bus.clr = 0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk_en = 1'b1;
    cmp("rst_ones", bus.ones_cnt, 0);
    cmp("rst_alarm", bus.alarm, 0);
    cmp("rst_run_len", bus.run_len, 0);

    // 111 detected on third bit.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    cmp("r035_ones", bus.ones_cnt, 1);
    cmp("r035_evt_valid", bus.evt_valid, 1);
    cmp("r035_evt_type", bus.evt_type, 1);
    cmp("r035_run_len", bus.run_len, 3);
    cmp("r035_err", bus.err, 0);
    cmp("r035_model_ones", m_ones, 1);
    step(0, 0, 0, 0);
    cmp("r035_pulse_end", bus.evt_valid, 0);

    // Eight zeros, alarm after the sixth.
    step(0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      step(0, (i >= 3), 0, 0);
      if (i == 5) cmp("r036_alarm_pre", bus.alarm, 0);
      if (i == 6) cmp("r036_alarm_rise", bus.alarm, 1);
    end
    cmp("r036_zeros", bus.zeros_cnt, 6);
    cmp("r036_max_run", bus.max_run, 8);
    cmp("r036_zeros_w2", bus2.zeros_cnt, 3);
    cmp("r036_model_zeros", m_zeros, 6);
    cmp("r036_err", bus.err, 0);

    // Toggle drops alarm; a fresh run of six re-raises it from TRACK.
    step(1, 0, 0, 0);
    cmp("r037_alarm_fall", bus.alarm, 0);
    cmp("r037_run_len", bus.run_len, 1);
    for (int i = 2; i <= 6; i++) step(1, (i >= 3), 0, 0);
    cmp("r037_alarm_again", bus.alarm, 1);
    cmp("r037_ones", bus.ones_cnt, 4);

    // det on the second bit of a run, then clr, then clr+det.
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    cmp("r038_err_set", bus.err, 1);
    step(0, 1, 0, 0);
    cmp("r038_err_sticky", bus.err, 1);
    step(0, 1, 1, 0);
    cmp("r038_err_clr", bus.err, 0);
    cmp("r040_zeros_clr", bus.zeros_cnt, 0);
    cmp("r040_no_evt", bus.evt_valid, 0);
    cmp("r038_max_clr", bus.max_run, 0);
    step(0, 1, 0, 0);
    cmp("r040_err_after", bus.err, 0);
    cmp("r040_zeros_after", bus.zeros_cnt, 1);
    cmp("r040_run_len", bus.run_len, 5);

    // Five 111 detections saturate the 2-bit counter; long run saturates run_len.
    step(1, 0, 0, 1);
    for (int i = 1; i <= 7; i++) step(1, (i >= 3), 0, 0);
    cmp("r039_ones_w2", bus2.ones_cnt, 3);
    cmp("r039_ones", bus.ones_cnt, 5);
    for (int i = 0; i < 15; i++) step(1, 1, 0, 0);
    cmp("r030_run_len", bus.run_len, 15);
    cmp("r030_alarm", bus.alarm, 1);
    cmp("r030_max", bus.max_run, 15);
    cmp("r030_model_run", m_run, 15);

    // Reset mid-run: next bit starts a run of 1.
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    cmp("r032_run_len", bus.run_len, 1);
    cmp("r032_err", bus.err, 0);

    // Randomized stream with a mostly-consistent upstream detector.
    for (int n = 0; n < 3000; n++) begin
      rr = ($urandom_range(0, 199) == 0);
      cr = ($urandom_range(0, 39) == 0);
      xr = ($urandom_range(0, 4) == 0) ? ~m_prev : m_prev;
      dr = (m_eff(xr) >= 3) ^ ($urandom_range(0, 49) == 0);
      step(xr, dr, cr, rr);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
